// File: rtl/rtc_seq_ctrl.sv
// rtl/rtc_seq_ctrl.sv - RTC bus sequencer FSM with start/done handshake, timeout and programming lock
module rtc_seq_ctrl #(
  parameter int NCH    = 3,
  parameter int NREAD  = 9,
  parameter int GAP    = 16,
  parameter int TO_CYC = 64,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [NCH-1:0] prog_req,
  input  logic           fmt,
  input  logic           crono_run,
  input  logic           crono_fin,
  input  logic           bus_done,
  output logic           bus_start,
  output logic [1:0]     bus_op,
  output logic [CW-1:0]  bus_ch,
  output logic [3:0]     rd_idx,
  output logic [NCH-1:0] edit_en,
  output logic           lock,
  output logic           data_valid,
  output logic           busy,
  output logic           err
);

  localparam int GW = $clog2(GAP + 1);
  localparam int TW = $clog2(TO_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_CFG, S_CRST, S_READ, S_EDIT, S_SAVE} state_t;

  state_t        state, state_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          waiting, waiting_n;
  logic [3:0]    rd_idx_n;
  logic          lock_n;
  logic          cfg_lock, cfg_lock_n;
  logic [CW-1:0] ch, ch_n, low_idx;
  logic          fmt_ref, run_ref, fin_ref;
  logic          fmt_ref_n, run_ref_n, fin_ref_n;
  logic          in_op, op_done;

  // Bus-owning states; bus_done only counts while an op is outstanding
  assign in_op   = (state == S_CFG) || (state == S_CRST) || (state == S_READ) || (state == S_SAVE);
  assign op_done = in_op && waiting && bus_done;
  assign busy    = (state != S_IDLE);
  assign bus_ch  = ch;

  // Lowest requesting channel wins the edit slot
  always_comb begin
    low_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (prog_req[i]) low_idx = CW'(i);
    end
  end

  // Opcode is a pure function of the op state, so it stays stable for the whole transaction
  always_comb begin
    case (state)
      S_CFG:   bus_op = 2'd1;
      S_SAVE:  bus_op = 2'd2;
      S_CRST:  bus_op = 2'd3;
      default: bus_op = 2'd0;
    endcase
  end

  // One-hot edit indicator for the channel held in ch
  always_comb begin
    edit_en = '0;
    if (state == S_EDIT) edit_en[ch] = 1'b1;
  end

  // State and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= S_IDLE;
      gap_cnt  <= '0;
      to_cnt   <= '0;
      waiting  <= 1'b0;
      rd_idx   <= '0;
      lock     <= 1'b0;
      cfg_lock <= 1'b0;
      ch       <= '0;
      fmt_ref  <= 1'b0;
      run_ref  <= 1'b0;
      fin_ref  <= 1'b0;
    end else begin
      state    <= state_n;
      gap_cnt  <= gap_cnt_n;
      to_cnt   <= to_cnt_n;
      waiting  <= waiting_n;
      rd_idx   <= rd_idx_n;
      lock     <= lock_n;
      cfg_lock <= cfg_lock_n;
      ch       <= ch_n;
      fmt_ref  <= fmt_ref_n;
      run_ref  <= run_ref_n;
      fin_ref  <= fin_ref_n;
    end
  end

  // Next-state, handshake/timeout and pulse outputs
  always_comb begin
    state_n    = state;
    gap_cnt_n  = gap_cnt;
    to_cnt_n   = to_cnt;
    waiting_n  = waiting;
    rd_idx_n   = rd_idx;
    lock_n     = lock;
    cfg_lock_n = cfg_lock;
    ch_n       = ch;
    fmt_ref_n  = fmt_ref;
    run_ref_n  = run_ref;
    fin_ref_n  = fin_ref;
    bus_start  = 1'b0;
    err        = 1'b0;
    data_valid = 1'b0;

    // Shared handshake: start in the first cycle, then wait; done beats expiry in the same cycle
    if (in_op) begin
      if (!waiting) begin
        bus_start = 1'b1;
        waiting_n = 1'b1;
        to_cnt_n  = TW'(1);
      end else if (bus_done) begin
        waiting_n = 1'b0;
        to_cnt_n  = '0;
      end else if (to_cnt == TW'(TO_CYC)) begin
        err       = 1'b1;
        waiting_n = 1'b0;
        to_cnt_n  = '0;
        rd_idx_n  = '0;
        state_n   = S_IDLE;
      end else begin
        to_cnt_n = to_cnt + TW'(1);
      end
    end

    case (state)
      S_IDLE: begin
        if (gap_cnt == GW'(GAP - 1)) begin
          gap_cnt_n = '0;
          state_n   = S_CHECK;
        end else begin
          gap_cnt_n = gap_cnt + GW'(1);
        end
      end
      S_CHECK: begin
        // fin_ref tracks the falling edge so the next rise is seen again
        if (!crono_fin) fin_ref_n = 1'b0;
        if ((fmt != fmt_ref) || (crono_run != run_ref) || (crono_fin && !fin_ref)) begin
          cfg_lock_n = 1'b0;
          state_n    = S_CFG;
        end else if ((prog_req != '0) && !lock) begin
          cfg_lock_n = 1'b1;
          state_n    = S_CFG;
        end else if (lock && (prog_req == '0)) begin
          lock_n  = 1'b0;
          state_n = S_READ;
        end else if (crono_fin && !crono_run) begin
          state_n = S_CRST;
        end else if (lock) begin
          ch_n    = low_idx;
          state_n = S_EDIT;
        end else begin
          state_n = S_READ;
        end
      end
      S_CFG: begin
        if (op_done) begin
          if (cfg_lock) begin
            lock_n = 1'b1;
          end else begin
            fmt_ref_n = fmt;
            run_ref_n = crono_run;
            fin_ref_n = crono_fin;
          end
          state_n = S_READ;
        end
      end
      S_CRST: begin
        if (op_done) state_n = S_READ;
      end
      S_READ: begin
        if (op_done) begin
          if (rd_idx == 4'(NREAD - 1)) begin
            data_valid = 1'b1;
            rd_idx_n   = '0;
            state_n    = S_IDLE;
          end else begin
            rd_idx_n = rd_idx + 4'd1;
          end
        end
      end
      S_EDIT: begin
        if (!prog_req[ch]) state_n = S_SAVE;
      end
      S_SAVE: begin
        if (op_done) begin
          lock_n  = 1'b0;
          state_n = S_READ;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rtc_seq_ctrl.sv
// tb/tb_rtc_seq_ctrl.sv - directed self-checking bench for rtc_seq_ctrl
`timescale 1ns/1ps
module tb_rtc_seq_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] prog_req = 3'b000;
  logic       fmt = 1'b0, crono_run = 1'b0, crono_fin = 1'b0;
  logic       drv_done = 1'b0, man_done = 1'b0, drv_en = 1'b0;
  logic       bus_done;
  logic       bus_start;
  logic [1:0] bus_op;
  logic [1:0] bus_ch;
  logic [3:0] rd_idx;
  logic [2:0] edit_en;
  logic       lock, data_valid, busy, err;

  int cyc = 0, base = 0;
  int n_checks = 0, n_fail = 0;

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  ch;
    logic [3:0]  idx;
    logic [31:0] cyc;
  } txn_t;

  txn_t txq[$];
  int   dv_q[$];
  int   err_q[$];

  assign bus_done = drv_done | man_done;

  rtc_seq_ctrl dut (
    .clock(clock), .reset(reset), .prog_req(prog_req), .fmt(fmt),
    .crono_run(crono_run), .crono_fin(crono_fin), .bus_done(bus_done),
    .bus_start(bus_start), .bus_op(bus_op), .bus_ch(bus_ch), .rd_idx(rd_idx),
    .edit_en(edit_en), .lock(lock), .data_valid(data_valid), .busy(busy), .err(err)
  );

  // 10 ns clock
  always #5 clock = ~clock;

  // Free-running cycle counter
  always @(posedge clock) cyc <= cyc + 1;

  // Log starts, data_valid and err pulses with cycle numbers relative to reset release
  always @(negedge clock) begin
    if (bus_start === 1'b1) txq.push_back({bus_op, bus_ch, rd_idx, 32'(cyc - base)});
    if (data_valid === 1'b1) dv_q.push_back(cyc - base);
    if (err === 1'b1) err_q.push_back(cyc - base);
  end

  // Bus driver model: done three cycles after each start
  initial begin
    forever begin
      @(negedge clock);
      if (bus_start === 1'b1 && drv_en && !reset) begin
        repeat (3) @(posedge clock);
        #1 drv_done = 1'b1;
        @(posedge clock);
        #1 drv_done = 1'b0;
      end
    end
  end

  task automatic wait_rel(input int n);
    while (cyc - base < n) @(negedge clock);
  endtask

  // Hold bus_done high for exactly cycle k
  task automatic pulse_done_at(input int k);
    wait_rel(k - 1);
    @(posedge clock);
    #1 man_done = 1'b1;
    @(posedge clock);
    #1 man_done = 1'b0;
  endtask

  task automatic do_reset(input logic en);
    @(negedge clock);
    reset = 1'b1; drv_en = en; prog_req = 3'b000;
    fmt = 1'b0; crono_run = 1'b0; crono_fin = 1'b0; man_done = 1'b0;
    repeat (6) @(negedge clock);
    txq.delete(); dv_q.delete(); err_q.delete();
    reset = 1'b0;
    base = cyc;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    n_checks++;
    if ({bus_start, bus_op, bus_ch, rd_idx, edit_en, lock, data_valid, busy, err} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all zero",
               {bus_start, bus_op, bus_ch, rd_idx, edit_en, lock, data_valid, busy, err});
    end
    do_reset(1'b1);
    wait_rel(5);
    n_checks++;
    if ({busy, bus_start, lock} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got busy/start/lock=%b required 000", {busy, bus_start, lock});
    end
  endtask

  task automatic test_refresh;
    txn_t t;
    wait_rel(60);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL refresh_gap_idle: got busy=%b required 0", busy);
    end
    wait_rel(130);
    for (int i = 0; i < 9; i++) begin
      t = (txq.size() > i) ? txq[i] : '0;
      n_checks++;
      if ({t.op, t.idx, t.cyc} !== {2'd0, 4'(i), 32'(17 + 4 * i)}) begin
        n_fail++;
        $display("FAIL refresh_read%0d: got op=%0d idx=%0d cyc=%0d required op=0 idx=%0d cyc=%0d",
                 i, t.op, t.idx, t.cyc, i, 17 + 4 * i);
      end
    end
    n_checks++;
    if (dv_q.size() < 2 || dv_q[0] != 52 || dv_q[1] != 105) begin
      n_fail++;
      $display("FAIL refresh_data_valid: got count=%0d first=%0d required count>=2 at 52,105",
               dv_q.size(), (dv_q.size() > 0) ? dv_q[0] : -1);
    end
    t = (txq.size() > 9) ? txq[9] : '0;
    n_checks++;
    if ({t.op, t.idx, t.cyc} !== {2'd0, 4'd0, 32'd70}) begin
      n_fail++;
      $display("FAIL refresh_repeat: got op=%0d idx=%0d cyc=%0d required op=0 idx=0 cyc=70", t.op, t.idx, t.cyc);
    end
  endtask

  task automatic test_cfg_change;
    txn_t t;
    int   c;
    do_reset(1'b1);
    wait_rel(30);
    fmt = 1'b1;
    wait_rel(170);
    t = (txq.size() > 9) ? txq[9] : '0;
    n_checks++;
    if ({t.op, t.cyc} !== {2'd1, 32'd70}) begin
      n_fail++;
      $display("FAIL cfg_op1: got op=%0d cyc=%0d required op=1 cyc=70", t.op, t.cyc);
    end
    t = (txq.size() > 10) ? txq[10] : '0;
    n_checks++;
    if ({t.op, t.idx, t.cyc} !== {2'd0, 4'd0, 32'd74}) begin
      n_fail++;
      $display("FAIL cfg_then_read: got op=%0d idx=%0d cyc=%0d required op=0 idx=0 cyc=74", t.op, t.idx, t.cyc);
    end
    t = (txq.size() > 19) ? txq[19] : '0;
    n_checks++;
    if ({t.op, t.idx, t.cyc} !== {2'd0, 4'd0, 32'd127}) begin
      n_fail++;
      $display("FAIL cfg_next_pass: got op=%0d idx=%0d cyc=%0d required op=0 idx=0 cyc=127", t.op, t.idx, t.cyc);
    end
    c = 0;
    foreach (txq[i]) if (txq[i].op == 2'd1) c++;
    n_checks++;
    if (c != 1) begin
      n_fail++;
      $display("FAIL cfg_op1_count: got %0d required 1", c);
    end
  endtask

  task automatic test_program;
    txn_t t;
    do_reset(1'b1);
    prog_req = 3'b011;
    wait_rel(25);
    n_checks++;
    if (lock !== 1'b1) begin
      n_fail++;
      $display("FAIL prog_lock_set: got %b required 1", lock);
    end
    wait_rel(76);
    n_checks++;
    if (edit_en !== 3'b001) begin
      n_fail++;
      $display("FAIL prog_edit_en: got %b required 001", edit_en);
    end
    wait_rel(80);
    prog_req = 3'b010;
    wait_rel(82);
    n_checks++;
    if (edit_en !== 3'b000) begin
      n_fail++;
      $display("FAIL prog_edit_clear: got %b required 000", edit_en);
    end
    wait_rel(84);
    n_checks++;
    if (lock !== 1'b1) begin
      n_fail++;
      $display("FAIL prog_lock_during_save: got %b required 1", lock);
    end
    wait_rel(86);
    n_checks++;
    if (lock !== 1'b0) begin
      n_fail++;
      $display("FAIL prog_lock_release: got %b required 0", lock);
    end
    wait_rel(90);
    t = (txq.size() > 0) ? txq[0] : '0;
    n_checks++;
    if ({t.op, t.cyc} !== {2'd1, 32'd17}) begin
      n_fail++;
      $display("FAIL prog_op1: got op=%0d cyc=%0d required op=1 cyc=17", t.op, t.cyc);
    end
    t = (txq.size() > 10) ? txq[10] : '0;
    n_checks++;
    if ({t.op, t.ch, t.cyc} !== {2'd2, 2'd0, 32'd81}) begin
      n_fail++;
      $display("FAIL prog_save: got op=%0d ch=%0d cyc=%0d required op=2 ch=0 cyc=81", t.op, t.ch, t.cyc);
    end
    t = (txq.size() > 11) ? txq[11] : '0;
    n_checks++;
    if ({t.op, t.idx, t.cyc} !== {2'd0, 4'd0, 32'd85}) begin
      n_fail++;
      $display("FAIL prog_refresh_no_gap: got op=%0d idx=%0d cyc=%0d required op=0 idx=0 cyc=85", t.op, t.idx, t.cyc);
    end
  endtask

  task automatic test_chrono;
    txn_t t;
    int   c1, c3;
    do_reset(1'b1);
    crono_fin = 1'b1;
    crono_run = 1'b0;
    wait_rel(79);
    crono_fin = 1'b0;
    wait_rel(160);
    t = (txq.size() > 0) ? txq[0] : '0;
    n_checks++;
    if ({t.op, t.cyc} !== {2'd1, 32'd17}) begin
      n_fail++;
      $display("FAIL chrono_op1: got op=%0d cyc=%0d required op=1 cyc=17", t.op, t.cyc);
    end
    t = (txq.size() > 10) ? txq[10] : '0;
    n_checks++;
    if ({t.op, t.cyc} !== {2'd3, 32'd74}) begin
      n_fail++;
      $display("FAIL chrono_op3: got op=%0d cyc=%0d required op=3 cyc=74", t.op, t.cyc);
    end
    t = (txq.size() > 11) ? txq[11] : '0;
    n_checks++;
    if ({t.op, t.idx, t.cyc} !== {2'd0, 4'd0, 32'd78}) begin
      n_fail++;
      $display("FAIL chrono_read_after: got op=%0d idx=%0d cyc=%0d required op=0 idx=0 cyc=78", t.op, t.idx, t.cyc);
    end
    t = (txq.size() > 20) ? txq[20] : '0;
    n_checks++;
    if ({t.op, t.idx, t.cyc} !== {2'd0, 4'd0, 32'd131}) begin
      n_fail++;
      $display("FAIL chrono_fall_quiet: got op=%0d idx=%0d cyc=%0d required op=0 idx=0 cyc=131", t.op, t.idx, t.cyc);
    end
    c1 = 0; c3 = 0;
    foreach (txq[i]) begin
      if (txq[i].op == 2'd1) c1++;
      if (txq[i].op == 2'd3) c3++;
    end
    n_checks++;
    if (c1 != 1 || c3 != 1) begin
      n_fail++;
      $display("FAIL chrono_op_counts: got op1=%0d op3=%0d required 1 and 1", c1, c3);
    end
  endtask

  task automatic test_timeout;
    do_reset(1'b1);
    prog_req = 3'b001;
    wait_rel(20);
    drv_en = 1'b0;
    wait_rel(50);
    n_checks++;
    if ({busy, bus_op, rd_idx} !== 7'b1_00_0000) begin
      n_fail++;
      $display("FAIL timeout_hold: got busy/op/idx=%b required 1000000", {busy, bus_op, rd_idx});
    end
    wait_rel(84);
    n_checks++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: got err=%b required 0 at cycle 84", err);
    end
    wait_rel(85);
    n_checks++;
    if ({err, busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL timeout_err: got err/busy=%b required 11 at cycle 85", {err, busy});
    end
    wait_rel(86);
    n_checks++;
    if ({err, busy, lock} !== 3'b001) begin
      n_fail++;
      $display("FAIL timeout_after: got err/busy/lock=%b required 001", {err, busy, lock});
    end
    wait_rel(90);
    n_checks++;
    if (err_q.size() != 1 || err_q[0] != 85) begin
      n_fail++;
      $display("FAIL timeout_pulse_count: got count=%0d required one pulse at 85", err_q.size());
    end
  endtask

  task automatic test_done_wins;
    txn_t t;
    do_reset(1'b0);
    pulse_done_at(81);
    wait_rel(90);
    n_checks++;
    if (err_q.size() != 0) begin
      n_fail++;
      $display("FAIL done_wins_err: got %0d err pulses required 0", err_q.size());
    end
    t = (txq.size() > 1) ? txq[1] : '0;
    n_checks++;
    if ({t.op, t.idx, t.cyc} !== {2'd0, 4'd1, 32'd82}) begin
      n_fail++;
      $display("FAIL done_wins_next: got op=%0d idx=%0d cyc=%0d required op=0 idx=1 cyc=82", t.op, t.idx, t.cyc);
    end
  endtask

  task automatic test_reset_mid_save;
    txn_t t;
    do_reset(1'b1);
    prog_req = 3'b001;
    wait_rel(75);
    drv_en = 1'b0;
    wait_rel(76);
    prog_req = 3'b000;
    wait_rel(78);
    n_checks++;
    if ({busy, bus_op, lock} !== 4'b1_10_1) begin
      n_fail++;
      $display("FAIL midsave_in_save: got busy/op/lock=%b required 1101", {busy, bus_op, lock});
    end
    reset = 1'b1;
    wait_rel(79);
    n_checks++;
    if ({bus_start, bus_op, bus_ch, rd_idx, edit_en, lock, data_valid, busy, err} !== 16'd0) begin
      n_fail++;
      $display("FAIL midsave_reset_outputs: got %b required all zero",
               {bus_start, bus_op, bus_ch, rd_idx, edit_en, lock, data_valid, busy, err});
    end
    wait_rel(80);
    reset = 1'b0;
    pulse_done_at(83);
    wait_rel(85);
    n_checks++;
    if ({busy, lock, err} !== 3'b000) begin
      n_fail++;
      $display("FAIL midsave_late_done: got busy/lock/err=%b required 000", {busy, lock, err});
    end
    wait_rel(100);
    t = (txq.size() > 10) ? txq[10] : '0;
    n_checks++;
    if ({t.op, t.ch, t.cyc} !== {2'd2, 2'd0, 32'd77}) begin
      n_fail++;
      $display("FAIL midsave_save_start: got op=%0d ch=%0d cyc=%0d required op=2 ch=0 cyc=77", t.op, t.ch, t.cyc);
    end
    t = (txq.size() > 11) ? txq[11] : '0;
    n_checks++;
    if ({t.op, t.idx, t.cyc} !== {2'd0, 4'd0, 32'd97} || err_q.size() != 0) begin
      n_fail++;
      $display("FAIL midsave_restart: got op=%0d idx=%0d cyc=%0d errs=%0d required op=0 idx=0 cyc=97 errs=0",
               t.op, t.idx, t.cyc, err_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_refresh();
    test_cfg_change();
    test_program();
    test_chrono();
    test_timeout();
    test_done_wins();
    test_reset_mid_save();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
